// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and constants.
// State encoding and default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// master drives the request, slave returns the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryOut;

  modport master (
    output start, a, b, carryIn,
    input  busy, done, sum, carryOut
  );

  modport slave (
    input  start, a, b, carryIn,
    output busy, done, sum, carryOut
  );

endinterface

// File: rtl/serial_adder_full_add.sv
// Single-bit full adder cell used by the serial datapath.
// Purely combinational.
module full_add (
  output logic sum,
  output logic carryOut,
  input  logic a,
  input  logic b,
  input  logic carryIn
);

  assign {carryOut, sum} = {1'b0, a} + {1'b0, b}
                         + {1'b0, carryIn};

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first,
// with a registered carry and a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    count;
  logic             carry_reg;
  logic             carry_q;
  logic             s_bit;
  logic             c_bit;
  logic             last;
  logic             load;

  full_add u_fa (
    .sum      (s_bit),
    .carryOut (c_bit),
    .a        (a_reg[0]),
    .b        (b_reg[0]),
    .carryIn  (carry_reg)
  );

  assign last = (count == CW'(WIDTH - 1));
  assign load = bus.start
              && (state == IDLE || state == DONE);

  // Works for WIDTH=1 too: the new bit lands in bit 0.
  always_comb begin
    sum_shift = sum_reg >> 1;
    sum_shift[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): if (bus.start) state_nxt = RUN;
      (state == RUN):  if (last) state_nxt = DONE;
      (state == DONE): state_nxt = bus.start ? RUN : IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
    end else if (load) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      carry_reg <= bus.carryIn;
      count     <= '0;
    end else if (state == RUN) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      sum_reg   <= sum_shift;
      carry_reg <= c_bit;
      count     <= count + CW'(1);
      if (last) begin
        sum_q   <= sum_shift;
        carry_q <= c_bit;
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.carryOut = carry_q;

endmodule
